stream_mux: RTL and testbench

Parametrised N-bit, CHANNELS-way selector with per-channel valid/ready handshake and a registered output stage. It has two modes:
- Fixed: software select, as in the combinational mux tree.
- Round-robin: fair arbitration among requesting channels.

It feeds single-consumer datapaths such as the writeback bus and the memory request port from multiple producers.

---
 rtl/stream_mux_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 56 +++++
 rtl/stream_mux.sv | 194 +++++++++++++++++++
 tb/tb_stream_mux.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
// Shared types and helpers for the stream_mux slice.
//   mux_mode_t : selection mode (fixed software select / round-robin)
//   slice_lo   : low bit index of channel `idx` inside a packed bus of
//                `width`-bit lanes
// -----------------------------------------------------------------------------
package stream_mux_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mux_mode_t;

   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Grants the first requesting channel
// found searching upward from (ptr+1) mod CHANNELS with wrap-around.
// Ports:
//   req         [CHANNELS]  request per channel
//   ptr         [SW]        last granted channel (search starts one above)
//   grant       [SW]        granted channel index (0 when nothing granted)
//   grant_valid             at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter  int CHANNELS = 32,
   localparam int SW       = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SW-1:0]       ptr,
   output logic [SW-1:0]       grant,
   output logic                grant_valid
);

   logic [SW-1:0]           start;
   logic [2*CHANNELS-1:0]   dbl_req;
   logic [2*CHANNELS-1:0]   mask;
   logic [2*CHANNELS-1:0]   masked;

   // The request vector is duplicated so that a wrap-around search becomes a
   // plain lowest-set-bit search: the lower copy is masked below the start
   // position, the upper copy is left whole and catches the wrapped part.
   always_comb begin
      if (ptr >= SW'(CHANNELS - 1)) begin
         start = '0;
      end else begin
         start = ptr + 1'b1;
      end

      mask = '0;
      for (int j = 0; j < 2 * CHANNELS; j++) begin
         mask[j] = (j >= int'(start));
      end

      dbl_req     = {req, req};
      masked      = dbl_req & mask;
      grant_valid = |req;

      // Downward scan so the lowest set bit is the last one written.
      grant = '0;
      for (int j = 2 * CHANNELS - 1; j >= 0; j--) begin
         if (masked[j]) begin
            grant = (j >= CHANNELS) ? SW'(j - CHANNELS) : SW'(j);
         end
      end
   end

endmodule

// File: rtl/stream_mux.sv
// -----------------------------------------------------------------------------
// stream_mux
// CHANNELS-way, N-bit stream selector with per-channel valid/ready and a
// registered output stage. mode=0 selects channel `s`; mode=1 arbitrates
// round-robin among requesting channels.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. Producers may raise or drop valid at will before
// a grant; once out_valid is high, out_data/out_sel stay stable until the
// consumer takes the word with out_ready.
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   s          channel index used in fixed mode
//   in_data    packed channel data, channel i at [i*N +: N]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (one-hot or zero)
//   out_data   registered selected word
//   out_valid  output holds a word
//   out_ready  consumer accepts the word
//   out_sel    channel that produced out_data
//
// Build option: STREAM_MUX_SKID_EN adds a one-entry skid register so that
// in_ready depends only on registered state (no out_ready->in_ready path).
// -----------------------------------------------------------------------------
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter  int N        = 32,
   parameter  int CHANNELS = 32,
   localparam int SW       = $clog2(CHANNELS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode,
   input  logic [SW-1:0]         s,
   input  logic [CHANNELS*N-1:0] in_data,
   input  logic [CHANNELS-1:0]   in_valid,
   output logic [CHANNELS-1:0]   in_ready,
   output logic [N-1:0]          out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SW-1:0]         out_sel
);

   logic [SW-1:0] rr_grant;
   logic          rr_valid;
   logic          fix_hit;
   logic [SW-1:0] grant;
   logic          grant_valid;
   logic [N-1:0]  grant_data;
   logic          accept;

   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  out_data_q,  out_data_d;
   logic [SW-1:0] out_sel_q,   out_sel_d;
   logic [SW-1:0] rr_ptr_q,    rr_ptr_d;

`ifdef STREAM_MUX_SKID_EN
   logic          skid_valid_q, skid_valid_d;
   logic [N-1:0]  skid_data_q,  skid_data_d;
   logic [SW-1:0] skid_sel_q,   skid_sel_d;
`endif

   rr_arbiter #(
      .CHANNELS (CHANNELS)
   ) u_rr_arbiter (
      .req         (in_valid),
      .ptr         (rr_ptr_q),
      .grant       (rr_grant),
      .grant_valid (rr_valid)
   );

   // Grant selection and data steering. An s beyond the last channel matches
   // no loop index, so it never grants.
   always_comb begin
      fix_hit = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (s == SW'(i) && in_valid[i]) begin
            fix_hit = 1'b1;
         end
      end

      if (mux_mode_t'(mode) == MODE_RR) begin
         grant       = rr_grant;
         grant_valid = rr_valid;
      end else begin
         grant       = fix_hit ? s : '0;
         grant_valid = fix_hit;
      end

      grant_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant == SW'(i)) begin
            grant_data = in_data[slice_lo(i, N) +: N];
         end
      end
   end

`ifdef STREAM_MUX_SKID_EN
   // Acceptance depends only on the skid being empty, never on out_ready.
   assign accept = grant_valid && !skid_valid_q && !rst;
`else
   // The output register can take a word when empty or being drained.
   assign accept = grant_valid && (!out_valid_q || out_ready) && !rst;
`endif

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         in_ready[i] = accept && (grant == SW'(i));
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      rr_ptr_d    = rr_ptr_q;
`ifdef STREAM_MUX_SKID_EN
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_sel_d   = skid_sel_q;

      if (out_valid_q && out_ready) begin
         // Output slot frees: an older skid word has priority over new input
         // (and new input is never accepted while the skid is full).
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_sel_d    = skid_sel_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_data_d = grant_data;
            out_sel_d  = grant;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (!out_valid_q) begin
         // The skid is always empty while the output is empty.
         if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_sel_d   = grant;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = grant_data;
         skid_sel_d   = grant;
      end
`else
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = grant_data;
         out_sel_d   = grant;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
`endif
      // The pointer only moves on round-robin grants so fairness resumes
      // where it left off after a stretch of fixed-mode traffic.
      if (accept && mux_mode_t'(mode) == MODE_RR) begin
         rr_ptr_d = grant;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         rr_ptr_q    <= SW'(CHANNELS - 1);
`ifdef STREAM_MUX_SKID_EN
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_sel_q   <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_SKID_EN
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_sel_q   <= skid_sel_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux.sv
// -----------------------------------------------------------------------------
// tb_stream_mux
// Drives stream_mux (N=8, CHANNELS=6) through directed phases and a random
// phase. A queue-level model predicts in_ready, out_valid, out_data and
// out_sel every cycle; literal expectations pin key cases.
// -----------------------------------------------------------------------------
module tb_stream_mux;

   localparam int N  = 8;
   localparam int CH = 6;
   localparam int SW = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            mode;
   logic [SW-1:0]   s;
   logic [CH*N-1:0] in_data;
   logic [CH-1:0]   in_valid;
   logic [CH-1:0]   in_ready;
   logic [N-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;
   logic [SW-1:0]   out_sel;

   int errors = 0;
   int checks = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   stream_mux #(
      .N        (N),
      .CHANNELS (CH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .s         (s),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Words accepted but not yet delivered, as {sel, data}. Capacity is one
   // word (plain build) or two (skid build).
   logic [N+SW-1:0] exp_q[$];
   logic [N+SW-1:0] last_w = '0;
   logic [N+SW-1:0] front;
   int              m_ptr = CH - 1;
   bit              live = 1'b0;
   bit              g_ok, cap_ok, accept, exp_v;
   int              g;
   logic [CH-1:0]   exp_rdy;

   always @(negedge clk) begin
      g_ok = 1'b0;
      g    = 0;
      if (mode == 1'b0) begin
         if (int'(s) < CH && in_valid[s]) begin
            g_ok = 1'b1;
            g    = int'(s);
         end
      end else begin
         for (int k = 1; k <= CH; k++) begin
            if (!g_ok && in_valid[(m_ptr + k) % CH]) begin
               g_ok = 1'b1;
               g    = (m_ptr + k) % CH;
            end
         end
      end
`ifdef STREAM_MUX_SKID_EN
      cap_ok = exp_q.size() < 2;
`else
      cap_ok = (exp_q.size() == 0) || out_ready;
`endif
      accept  = !rst && g_ok && cap_ok;
      exp_rdy = '0;
      if (accept) exp_rdy[g] = 1'b1;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));

      exp_v = exp_q.size() > 0;
      if (live) begin
         front = exp_v ? exp_q[0] : last_w;
         check("out_valid", 64'(out_valid), 64'(exp_v));
         check("out_data", 64'(out_data), 64'(front[N-1:0]));
         check("out_sel", 64'(out_sel), 64'(front[N+SW-1:N]));
      end

      if (rst) begin
         exp_q.delete();
         m_ptr  = CH - 1;
         last_w = '0;
         live   = 1'b1;
      end else begin
         if (exp_v && out_ready) last_w = exp_q.pop_front();
         if (accept) begin
            exp_q.push_back({SW'(g), in_data[g*N +: N]});
            if (mode) m_ptr = g;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ramp();
      for (int i = 0; i < CH; i++) in_data[i*N +: N] = N'(i * 17);
   endtask

   task automatic randomize_inputs();
      in_valid  = CH'($urandom_range(0, (1 << CH) - 1));
      out_ready = 1'($urandom_range(0, 1));
      s         = SW'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      rst       = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < CH; i++) in_data[i*N +: N] = N'($urandom);
   endtask

   // ---------------- stimulus ----------------
   int rr_seq[6] = '{0, 1, 3, 0, 1, 3};
`ifdef STREAM_MUX_SKID_EN
   logic [CH-1:0] rdy_before;
`endif

   initial begin
      rst = 1'b1; mode = 1'b1; s = '0; in_valid = '1; out_ready = 1'b1;
      set_ramp();

      // Reset with every producer requesting.
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(0));
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("first_grant", 64'(in_ready), 64'(6'b000001));
      tick();
      @(negedge clk);
      check("first_sel", 64'(out_sel), 64'(0));
      check("first_valid", 64'(out_valid), 64'(1));

      // Fixed select of channel 5.
      tick();
      mode = 1'b0; s = 3'd5;
      @(negedge clk);
      check("fix_ready", 64'(in_ready), 64'(6'b100000));
      repeat (3) begin
         tick();
         @(negedge clk);
         check("fix_data", 64'(out_data), 64'(8'h55));
         check("fix_sel", 64'(out_sel), 64'(5));
      end

      // Round-robin fairness over channels 0,1,3.
      tick();
      rst = 1'b1; mode = 1'b1; in_valid = 6'b001011;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         @(negedge clk);
         check("rr_seq", 64'(out_sel), 64'(rr_seq[k]));
         check("rr_skip2", 64'(in_ready[2]), 64'(0));
      end

      // Backpressure: hold channel 0's word for three cycles.
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_sel", 64'(out_sel), 64'(0));
         check("bp_data", 64'(out_data), 64'(0));
         if (c > 0) check("bp_ready", 64'(in_ready), 64'(0));
         tick();
      end
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("bp_resume", 64'(out_sel), 64'(1));

      // Out-of-range fixed select never grants.
      in_valid = '0;
      repeat (3) tick();
      mode = 1'b0; s = 3'd7; in_valid = '1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("s7_valid", 64'(out_valid), 64'(0));
         check("s7_ready", 64'(in_ready), 64'(0));
         tick();
      end

      // Mode switch while stalled leaves the held word alone.
      s = 3'd2; out_ready = 1'b0;
      tick();
      mode = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("stall_data", 64'(out_data), 64'(8'h22));
         check("stall_sel", 64'(out_sel), 64'(2));
         tick();
      end
      out_ready = 1'b1;
      repeat (4) tick();

      // Random traffic.
      for (int c = 0; c < 2000; c++) begin
         randomize_inputs();
`ifdef STREAM_MUX_SKID_EN
         @(negedge clk);
         #1;
         rdy_before = in_ready;
         out_ready  = ~out_ready;
         #1;
         check("ready_indep", 64'(in_ready), 64'(rdy_before));
         out_ready  = ~out_ready;
`endif
         tick();
      end
      rst = 1'b0; out_ready = 1'b1; in_valid = '0;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
